// File: rtl/usb3_tx_pkg.sv
// Shared types and constants for the USB3 transmit scheduler (usb3_tx_sched).
package usb3_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_LC = 2'd1,
    GNT_HP = 2'd2,
    GNT_DP = 2'd3
  } state_t;

  localparam logic [31:0] IDLE_DATA     = 32'h0000_0000;
  localparam logic [3:0]  IDLE_DATAK    = 4'h0;
  localparam int          MAX_BURST_DEF = 256;
  localparam int          CNT_W         = 9;

endpackage

// File: rtl/usb3_tx_arb.sv
// Source picker for usb3_tx_sched: lc always first; hp/dp fixed priority, or
// round-robin with a last-served register when USB3_TX_SCHED_RR_EN is defined.
module usb3_tx_arb
  import usb3_tx_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   take,
  input  logic   lc_valid,
  input  logic   hp_valid,
  input  logic   dp_valid,
  output state_t pick,
  output logic   pick_valid
);

  logic hp_wins;

`ifdef USB3_TX_SCHED_RR_EN
  // Set when hp was the most recent hp/dp grant, so dp wins the next tie.
  logic hp_last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hp_last_q <= 1'b0;
    end else if (take && (pick != GNT_LC)) begin
      hp_last_q <= (pick == GNT_HP);
    end
  end

  assign hp_wins = hp_valid && (!dp_valid || !hp_last_q);
`else
  logic unused_arb;
  assign unused_arb = ^{clk, rst_n, take};
  assign hp_wins    = hp_valid;
`endif

  always_comb begin
    pick_valid = lc_valid | hp_valid | dp_valid;
    pick       = IDLE;
    if (lc_valid) begin
      pick = GNT_LC;
    end else if (hp_wins) begin
      pick = GNT_HP;
    end else if (dp_valid) begin
      pick = GNT_DP;
    end
  end

endmodule

// File: rtl/usb3_tx_sched.sv
// USB3 transmit scheduler: grants lc/hp/dp bursts onto the scrambler feed.
// Optional round-robin hp/dp arbitration with macro USB3_TX_SCHED_RR_EN.
module usb3_tx_sched
  import usb3_tx_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ltssm_skp_inhibit,
  input  logic        lc_valid,
  input  logic [31:0] lc_data,
  input  logic [3:0]  lc_datak,
  input  logic        lc_last,
  output logic        lc_ready,
  input  logic        hp_valid,
  input  logic [31:0] hp_data,
  input  logic [3:0]  hp_datak,
  input  logic        hp_last,
  output logic        hp_ready,
  input  logic        dp_valid,
  input  logic [31:0] dp_data,
  input  logic [3:0]  dp_datak,
  input  logic        dp_last,
  output logic        dp_ready,
  input  logic        raw_stall,
  output logic [31:0] raw_data,
  output logic [3:0]  raw_datak,
  output logic        raw_active,
  output logic        skp_defer,
  output logic        skp_inhibit,
  output logic        err_underrun,
  output logic        err_overrun,
  output logic [1:0]  dbg_state_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_t             state_q, state_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         datak_q, datak_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               under_q, under_d;
  logic               over_q, over_d;
  logic               defer_q, inhib_q;

  logic               sel_valid, sel_last;
  logic [31:0]        sel_data;
  logic [3:0]         sel_datak;
  logic               grant_ok, arb_take, pick_valid;
  state_t             pick;

  usb3_tx_arb u_arb (
    .clk        (local_clk),
    .rst_n      (reset_n),
    .take       (arb_take),
    .lc_valid   (lc_valid),
    .hp_valid   (hp_valid),
    .dp_valid   (dp_valid),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  // Valid/ready: a source word transfers on a rising edge where s_valid and
  // s_ready are both high; s_ready never depends on s_valid.
  assign grant_ok = reset_n && enable && !raw_stall;
  assign lc_ready = grant_ok && (state_q == GNT_LC);
  assign hp_ready = grant_ok && (state_q == GNT_HP);
  assign dp_ready = grant_ok && (state_q == GNT_DP);
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = IDLE_DATA;
    sel_datak = IDLE_DATAK;
    case (state_q)
      GNT_LC: begin
        sel_valid = lc_valid; sel_last = lc_last; sel_data = lc_data; sel_datak = lc_datak;
      end
      GNT_HP: begin
        sel_valid = hp_valid; sel_last = hp_last; sel_data = hp_data; sel_datak = hp_datak;
      end
      GNT_DP: begin
        sel_valid = dp_valid; sel_last = dp_last; sel_data = dp_data; sel_datak = dp_datak;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    datak_d  = datak_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    under_d  = 1'b0;
    over_d   = 1'b0;
    arb_take = 1'b0;
    if (!enable) begin
      // Disabling drops any partial burst silently.
      state_d  = IDLE;
      data_d   = IDLE_DATA;
      datak_d  = IDLE_DATAK;
      active_d = 1'b0;
    end else if (!raw_stall) begin
      if (state_q == IDLE) begin
        data_d   = IDLE_DATA;
        datak_d  = IDLE_DATAK;
        active_d = 1'b0;
        cnt_d    = '0;
        if (pick_valid) begin
          state_d  = pick;
          arb_take = 1'b1;
        end
      end else if (sel_valid) begin
        data_d   = sel_data;
        datak_d  = sel_datak;
        active_d = 1'b1;
        cnt_d    = cnt_inc;
        if (sel_last) begin
          state_d = IDLE;
        end else if (cnt_inc == MAX_CNT) begin
          state_d = IDLE;
          over_d  = 1'b1;
        end
      end else begin
        data_d   = IDLE_DATA;
        datak_d  = IDLE_DATAK;
        active_d = 1'b0;
        under_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      data_q   <= IDLE_DATA;
      datak_q  <= IDLE_DATAK;
      active_q <= 1'b0;
      cnt_q    <= '0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
      defer_q  <= 1'b0;
      inhib_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      datak_q  <= datak_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      under_q  <= under_d;
      over_q   <= over_d;
      defer_q  <= (state_d != IDLE);
      inhib_q  <= ltssm_skp_inhibit;
    end
  end

  assign raw_data     = data_q;
  assign raw_datak    = datak_q;
  assign raw_active   = active_q;
  assign skp_defer    = defer_q;
  assign skp_inhibit  = inhib_q;
  assign err_underrun = under_q;
  assign err_overrun  = over_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_usb3_tx_sched.sv
// Directed scoreboard bench for usb3_tx_sched; words are predicted in order
// when a scenario is issued and popped by the monitor as they reach raw_*.
module tb_usb3_tx_sched;
  import usb3_tx_pkg::*;

  localparam int L_NONE  = 0;
  localparam int L_FINAL = 1;
  localparam int L_EACH  = 2;

  logic        local_clk;
  logic        reset_n;
  logic        enable;
  logic        ltssm_skp_inhibit;
  logic [2:0]  src_valid;
  logic [2:0]  src_last;
  logic [2:0]  src_ready;
  logic [31:0] src_data [3];
  logic [3:0]  src_datak [3];
  logic        raw_stall;
  logic [31:0] raw_data;
  logic [3:0]  raw_datak;
  logic        raw_active;
  logic        skp_defer;
  logic        skp_inhibit;
  logic        err_underrun;
  logic        err_overrun;
  logic [1:0]  dbg_state;

  logic [35:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          und_total = 0;
  int          ovr_total = 0;
  logic        mon_stall = 1'b0;

  usb3_tx_sched dut (
    .local_clk         (local_clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .ltssm_skp_inhibit (ltssm_skp_inhibit),
    .lc_valid          (src_valid[0]),
    .lc_data           (src_data[0]),
    .lc_datak          (src_datak[0]),
    .lc_last           (src_last[0]),
    .lc_ready          (src_ready[0]),
    .hp_valid          (src_valid[1]),
    .hp_data           (src_data[1]),
    .hp_datak          (src_datak[1]),
    .hp_last           (src_last[1]),
    .hp_ready          (src_ready[1]),
    .dp_valid          (src_valid[2]),
    .dp_data           (src_data[2]),
    .dp_datak          (src_datak[2]),
    .dp_last           (src_last[2]),
    .dp_ready          (src_ready[2]),
    .raw_stall         (raw_stall),
    .raw_data          (raw_data),
    .raw_datak         (raw_datak),
    .raw_active        (raw_active),
    .skp_defer         (skp_defer),
    .skp_inhibit       (skp_inhibit),
    .err_underrun      (err_underrun),
    .err_overrun       (err_overrun),
    .dbg_state_o       (dbg_state)
  );

  // Clock / watchdog
  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: a fresh word is on raw_* when active and the previous edge was not stalled.
  always @(negedge local_clk) begin
    logic [35:0] e;
    if (raw_active === 1'b1 && !mon_stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h, required no word", {raw_datak, raw_data});
      end else begin
        e = exp_q.pop_front();
        chk("raw_word", 64'({raw_datak, raw_data}), 64'(e));
      end
    end
    mon_stall = raw_stall;
    if (err_underrun === 1'b1) und_total++;
    if (err_overrun === 1'b1) ovr_total++;
  end

  // Driver tasks
  task automatic push_burst(input int n, input logic [31:0] d0, input logic [31:0] inc,
                            input logic [3:0] k);
    for (int i = 0; i < n; i++) exp_q.push_back({k, d0 + inc * 32'(i)});
  endtask

  task automatic wait_accept(input logic [1:0] s);
    logic acc;
    int   waited;
    acc    = 1'b0;
    waited = 0;
    while (!acc) begin
      @(negedge local_clk);
      acc = src_ready[s];
      @(posedge local_clk);
      #1;
      waited++;
      if (!acc && waited > 64) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout src %0d: got no ready in %0d cycles, required ready", s, waited);
        acc = 1'b1;
      end
    end
  endtask

  task automatic drv(input logic [1:0] s, input int n, input logic [31:0] d0,
                     input logic [31:0] inc, input logic [3:0] k, input int lmode,
                     input int gap_at);
    for (int i = 0; i < n; i++) begin
      src_valid[s] = 1'b1;
      src_data[s]  = d0 + inc * 32'(i);
      src_datak[s] = k;
      src_last[s]  = (lmode == L_EACH) || (lmode == L_FINAL && i == n - 1);
      wait_accept(s);
      if (i == gap_at) begin
        src_valid[s] = 1'b0;
        @(posedge local_clk);
        #1;
      end
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  initial begin
    int u0, o0;
    reset_n           = 1'b0;
    enable            = 1'b0;
    ltssm_skp_inhibit = 1'b0;
    raw_stall         = 1'b0;
    src_valid         = '0;
    src_last          = '0;
    for (int i = 0; i < 3; i++) begin
      src_data[i]  = '0;
      src_datak[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge local_clk);
    @(negedge local_clk);
    chk("reset_outputs", 64'({raw_data, raw_datak, raw_active, skp_defer, skp_inhibit,
                              err_underrun, err_overrun, dbg_state, src_ready}), 64'(0));
    @(posedge local_clk);
    #1;
    reset_n = 1'b1;

    // Disabled: a valid lc source is never granted
    src_valid[0] = 1'b1;
    repeat (2) begin
      @(negedge local_clk);
      chk("disabled_idle", 64'({dbg_state, src_ready}), 64'({IDLE, 3'b000}));
    end
    @(posedge local_clk);
    #1;
    src_valid[0] = 1'b0;
    enable       = 1'b1;
    @(posedge local_clk);
    #1;

    // lc and hp valid in the same IDLE cycle: lc first, one idle cycle, then hp
    push_burst(2, 32'hFEFE_FEF7, 32'h0, 4'hF);
    push_burst(2, 32'h4800_0010, 32'h1, 4'h0);
    fork
      drv(2'd0, 2, 32'hFEFE_FEF7, 32'h0, 4'hF, L_FINAL, -1);
      drv(2'd1, 2, 32'h4800_0010, 32'h1, 4'h0, L_FINAL, -1);
      begin
        @(negedge local_clk);
        chk("tie_n_idle", 64'(dbg_state), 64'(IDLE));
        @(negedge local_clk);
        chk("tie_gnt_lc", 64'({dbg_state, src_ready, skp_defer}), 64'({GNT_LC, 3'b001, 1'b1}));
        @(negedge local_clk);
        chk("tie_n2_word", 64'({raw_active, raw_datak, raw_data}), 64'({1'b1, 4'hF, 32'hFEFE_FEF7}));
        @(negedge local_clk);
        chk("tie_n3_word", 64'({raw_active, raw_datak, raw_data, dbg_state}),
            64'({1'b1, 4'hF, 32'hFEFE_FEF7, IDLE}));
        @(negedge local_clk);
        chk("tie_gap_then_hp", 64'({raw_active, dbg_state, src_ready, skp_defer}),
            64'({1'b0, GNT_HP, 3'b010, 1'b1}));
      end
    join

    // raw_stall for 3 cycles mid hp burst
    push_burst(5, 32'h4800_0020, 32'h1, 4'h0);
    fork
      drv(2'd1, 5, 32'h4800_0020, 32'h1, 4'h0, L_FINAL, -1);
      begin
        repeat (3) @(posedge local_clk);
        #1;
        raw_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge local_clk);
          chk("stall_hold", 64'({src_ready[1], raw_active, raw_data}), 64'({1'b0, 1'b1, 32'h4800_0021}));
          @(posedge local_clk);
          #1;
        end
        raw_stall = 1'b0;
      end
    join

    // dp valid drops for one cycle mid burst
    u0 = und_total;
    push_burst(4, 32'hD000_0100, 32'h1, 4'h0);
    fork
      drv(2'd2, 4, 32'hD000_0100, 32'h1, 4'h0, L_FINAL, 1);
      begin
        repeat (4) @(posedge local_clk);
        @(negedge local_clk);
        chk("underrun_idle_word", 64'({raw_active, raw_data, raw_datak, err_underrun, dbg_state}),
            64'({1'b0, 32'h0, 4'h0, 1'b1, GNT_DP}));
      end
    join
    chk("underrun_once", 64'(und_total - u0), 64'(1));

    // 256-word dp burst with no last
    o0 = ovr_total;
    push_burst(256, 32'hD000_0200, 32'h1, 4'h0);
    fork
      drv(2'd2, 256, 32'hD000_0200, 32'h1, 4'h0, L_NONE, -1);
      begin
        repeat (256) @(posedge local_clk);
        @(negedge local_clk);
        chk("overrun_before", 64'({err_overrun, dbg_state}), 64'({1'b0, GNT_DP}));
        @(negedge local_clk);
        chk("overrun_pulse", 64'({err_overrun, dbg_state, raw_active, raw_data}),
            64'({1'b1, IDLE, 1'b1, 32'hD000_02FF}));
        @(negedge local_clk);
        chk("overrun_after", 64'({err_overrun, raw_active, raw_data, dbg_state}),
            64'({1'b0, 1'b0, 32'h0, IDLE}));
      end
    join
    chk("overrun_once", 64'(ovr_total - o0), 64'(1));

    // hp and dp continuously valid with 1-word bursts
`ifdef USB3_TX_SCHED_RR_EN
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({4'h0, 32'h4800_0040 + 32'(i)});
      exp_q.push_back({4'h0, 32'hD000_0400 + 32'(i)});
    end
`else
    push_burst(4, 32'h4800_0040, 32'h1, 4'h0);
    push_burst(4, 32'hD000_0400, 32'h1, 4'h0);
`endif
    fork
      drv(2'd1, 4, 32'h4800_0040, 32'h1, 4'h0, L_EACH, -1);
      drv(2'd2, 4, 32'hD000_0400, 32'h1, 4'h0, L_EACH, -1);
    join
    repeat (2) @(posedge local_clk);
    #1;

    // skp_inhibit is one register stage behind the LTSSM request
    ltssm_skp_inhibit = 1'b1;
    @(negedge local_clk);
    chk("skp_inhibit_pre", 64'(skp_inhibit), 64'(0));
    @(negedge local_clk);
    chk("skp_inhibit_post", 64'({skp_inhibit, skp_defer}), 64'({1'b1, 1'b0}));
    @(posedge local_clk);
    #1;
    ltssm_skp_inhibit = 1'b0;

    // Reset asserted while the third hp word is offered
    push_burst(2, 32'h4800_0060, 32'h1, 4'h0);
    src_valid[1] = 1'b1;
    src_data[1]  = 32'h4800_0060;
    src_datak[1] = 4'h0;
    src_last[1]  = 1'b0;
    repeat (2) @(posedge local_clk);
    #1;
    src_data[1] = 32'h4800_0061;
    @(posedge local_clk);
    #1;
    src_data[1] = 32'h4800_0062;
    reset_n     = 1'b0;
    @(negedge local_clk);
    chk("reset_ready_low", 64'(src_ready), 64'(0));
    @(posedge local_clk);
    #1;
    src_valid[1] = 1'b0;
    @(negedge local_clk);
    chk("reset_mid_burst", 64'({raw_data, raw_datak, raw_active, skp_defer, skp_inhibit,
                                err_underrun, err_overrun, dbg_state, src_ready}), 64'(0));
    @(posedge local_clk);
    #1;
    reset_n = 1'b1;

    repeat (3) @(posedge local_clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb3_tx_sched.md
USB3_TX_SCHED -- requirements
Module: usb3_tx_sched

Interface
REQ-001 SHALL provide parameter MAX_BURST, default 256, meaning the maximum number of dwords accepted in one grant before a forced abort.
REQ-002 SHALL provide port local_clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-003 SHALL provide port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL provide port enable, input, 1 bit: enables the scheduler; while low, no grants are made.
REQ-005 SHALL provide port ltssm_skp_inhibit, input, 1 bit: the LTSSM's request to inhibit SKP insertion.
REQ-006 SHALL provide, for each source s in {lc, hp, dp}, the inputs s_valid (1), s_data (32), s_datak (4) and s_last (1), plus output s_ready (1); lc is link command, hp is header packet, dp is data packet payload.
REQ-007 SHALL provide port raw_stall, input, 1 bit: scrambler back-pressure.
REQ-008 SHALL provide outputs raw_data (32), raw_datak (4) and raw_active (1), which feed the scrambler.
REQ-009 SHALL provide outputs skp_defer (1) and skp_inhibit (1), which feed the scrambler.
REQ-010 SHALL provide outputs err_underrun (1) and err_overrun (1), each a one-cycle pulse.

Function
REQ-011 SHALL implement states IDLE, GNT_LC, GNT_HP and GNT_DP, encoded in 2 bits.
REQ-012 In IDLE with enable=1, SHALL go next cycle to the highest-priority valid source (lc > hp > dp); with no valid source it SHALL stay in IDLE.
REQ-013 s_ready SHALL be combinational: it is 1 only when the state is GNT_s, raw_stall=0 and enable=1.
REQ-014 A word SHALL be accepted on a cycle with s_valid=1 and s_ready=1; raw_data and raw_datak SHALL then equal s_data and s_datak on the next cycle, with raw_active=1.
REQ-015 Accepting a word with s_last=1 SHALL move the state to IDLE next cycle; grants are non-preemptive.
REQ-016 There SHALL be a gap of at least one cycle in IDLE between bursts; the idle word is data 32'h0, datak 4'h0, raw_active=0.
REQ-017 While raw_stall=1, raw_data, raw_datak, raw_active and the state SHALL hold their values.
REQ-018 In a GNT state with s_valid=0 and raw_stall=0, SHALL drive the idle word and pulse err_underrun; the state SHALL NOT change.
REQ-019 A burst counter (9 bits) SHALL clear on entering a GNT state and increment on each accept.
REQ-020 If the counter reaches MAX_BURST with no last, SHALL pulse err_overrun, return to IDLE and drive the idle word.
REQ-021 skp_defer SHALL be registered and equal 1 in any GNT state, and 0 in IDLE.
REQ-022 skp_inhibit SHALL be ltssm_skp_inhibit delayed by one register stage.
REQ-023 If enable falls, SHALL go to IDLE next cycle, drop all readies that same cycle, and drive the idle word; a partial burst is discarded without error.
REQ-024 If lc and hp become valid in the same IDLE cycle, lc SHALL win.

Reset
REQ-025 While reset_n=0 at a clock edge, SHALL set the state to IDLE, raw_data to 0, raw_datak to 0, raw_active to 0, skp_defer to 0, skp_inhibit to 0, both err outputs to 0 and the burst counter to 0.
REQ-026 Reset asserted mid-burst SHALL take effect on the next edge; all s_ready SHALL read 0 during reset.

Configuration
REQ-027 SHALL support macro USB3_TX_SCHED_RR_EN: when defined, hp and dp are arbitrated round-robin (the last served of the two loses a tie, and lc still has top priority); when undefined, the fixed priority of REQ-012 applies.

Structure
REQ-028 SHALL place the state encoding, the idle-word constants and the default MAX_BURST in the shared package usb3_tx_pkg.
REQ-029 SHALL contain one sub-module, usb3_tx_arb: the combinational priority/round-robin picker including its last-served register.

Verification
REQ-030 Bench SHALL cover: lc and hp valid in the same IDLE cycle, lc 2 words with data 0xFEFEFEF7 and k=4'hF -> lc words appear on raw_* at cycles N+2 and N+3, and hp is granted only after one idle cycle.
REQ-031 Bench SHALL cover: raw_stall held high for 3 cycles mid-hp burst -> raw_* frozen, hp_ready=0, and no word lost or duplicated.
REQ-032 Bench SHALL cover: dp_valid drops for 1 cycle mid-burst -> one idle word with raw_active=0 and err_underrun pulsed exactly once.
REQ-033 Bench SHALL cover: a dp burst of 256 words with no last -> err_overrun on the cycle the counter reaches 256, then IDLE.
REQ-034 Bench SHALL cover: with RR_EN defined, hp and dp continuously valid with 1-word bursts -> grants alternate hp, dp, hp, dp.
REQ-035 Bench SHALL cover: reset_n=0 during the third word of a burst -> next cycle is all outputs 0, state IDLE, and all readies 0.
